// File: rtl/i2c_target_regif.sv
// I2C target front end: filtered SCL/SDA, START/STOP/address decode and a byte-wide
// register bus with an auto-incrementing pointer. No clock stretching.
`timescale 1ns/1ps
module i2c_target_regif #(
    parameter logic [6:0]  DEV_ADDR = 7'h40,
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic       SYSCLK,
    input  logic       RESET,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    output logic       REG_WR,
    output logic       REG_RD,
    input  logic [7:0] REG_RDATA,
    output logic       BUSY
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]      filt_q, filt_d, prev_q, prev_d;
    logic [1:0][2:0] fcnt_q, fcnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       ack_on_q, ack_on_d;
    logic       ptr_loaded_q, ptr_loaded_d;
    logic       busy_q, busy_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       load_q, load_d;

    logic       scl_f, sda_f, scl_p, sda_p;
    logic       scl_rise, scl_fall, start_det, stop_det, fire;
    logic [7:0] rx_byte;

    // A filtered level flips only after FILT_LEN consecutive differing samples.
    always_comb begin
        sync1_d = {SDA_IN, SCL_IN};
        sync2_d = sync1_q;
        prev_d  = filt_q;
        filt_d  = filt_q;
        fcnt_d  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == 3'(FILT_LEN - 1)) filt_d[i] = sync2_q[i];
                else fcnt_d[i] = fcnt_q[i] + 3'd1;
            end
        end
    end

    always_comb begin
        scl_f     = filt_q[0];
        sda_f     = filt_q[1];
        scl_p     = prev_q[0];
        sda_p     = prev_q[1];
        scl_rise  = scl_f & ~scl_p;
        scl_fall  = ~scl_f & scl_p;
        start_det = scl_f & scl_p & sda_p & ~sda_f;
        stop_det  = scl_f & scl_p & ~sda_p & sda_f;
        fire      = (hold_q == HOLD_W'(1));
        rx_byte   = {shift_q[6:0], sda_f};
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        ack_on_d     = ack_on_q;
        ptr_loaded_d = ptr_loaded_q;
        busy_d       = busy_q;
        sda_oe_d     = sda_oe_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        load_d       = rd_q;
        hold_d       = hold_q;

        if (scl_fall) hold_d = HOLD_W'(HOLD_CYC);
        else if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);

        // pointer bump lands the cycle after the write strobe
        if (wr_q) reg_addr_d = reg_addr_q + 8'd1;
        if (load_q) shift_d = REG_RDATA;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            hold_d   = '0;
        end else if (start_det) begin
            state_d      = ST_ADDR;
            bit_cnt_d    = '0;
            ptr_loaded_d = 1'b0;
            sda_oe_d     = 1'b0;
            ack_on_d     = 1'b0;
            hold_d       = '0;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            busy_d   = 1'b1;
                            rw_d     = rx_byte[0];
                            ack_on_d = 1'b0;
                            rd_d     = rx_byte[0];
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // first fire (8th fall) drives ACK, second fire (9th fall) leaves
                ST_ADDR_ACK, ST_WR_ACK: if (fire) begin
                    if (!ack_on_q) begin
                        sda_oe_d = 1'b1;
                        ack_on_d = 1'b1;
                    end else begin
                        ack_on_d  = 1'b0;
                        bit_cnt_d = '0;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d  = ST_RD_DATA;
                            sda_oe_d = ~shift_q[7];
                        end else begin
                            state_d  = ST_WR_DATA;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        state_d   = ST_WR_ACK;
                        ack_on_d  = 1'b0;
                        if (!ptr_loaded_q) begin
                            reg_addr_d   = rx_byte;
                            ptr_loaded_d = 1'b1;
                        end else begin
                            reg_wdata_d = rx_byte;
                            wr_d        = 1'b1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (fire) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                        end
                    end
                end
                ST_RD_ACK: if (scl_rise) begin
                    if (!sda_f) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        rd_d       = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = ST_RD_DATA;
                    end else begin
                        state_d = ST_IGNORE;
                        busy_d  = 1'b0;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            filt_q       <= '1;
            prev_q       <= '1;
            fcnt_q       <= '0;
            hold_q       <= '0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rw_q         <= 1'b0;
            ack_on_q     <= 1'b0;
            ptr_loaded_q <= 1'b0;
            busy_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            filt_q       <= filt_d;
            prev_q       <= prev_d;
            fcnt_q       <= fcnt_d;
            hold_q       <= hold_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            ack_on_q     <= ack_on_d;
            ptr_loaded_q <= ptr_loaded_d;
            busy_q       <= busy_d;
            sda_oe_q     <= sda_oe_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            load_q       <= load_d;
        end
    end

    assign SDA_OE    = sda_oe_q;
    assign REG_ADDR  = reg_addr_q;
    assign REG_WDATA = reg_wdata_q;
    assign REG_WR    = wr_q;
    assign REG_RD    = rd_q;
    assign BUSY      = busy_q;

endmodule
